// File: rtl/seven_seg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low 7-segment display
// by sampling its anode/segment drive lines and committing complete frames.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] AN,
    input  logic [6:0] SEG,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic [3:0] BLANK,
    output logic       FRAME_VALID,
    output logic       SEG_ERR,
    output logic       AN_ERR,
    output logic       STALE
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic {COLLECT, COMMIT} state_t;

    state_t          state, state_next;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic [7:0]      dwell, dwell_next;
    logic [IW-1:0]   idle;
    logic [3:0]      mask, mask_next;
    logic [3:0][3:0] sh_val;
    logic [3:0]      sh_blank;
    logic [3:0][3:0] dig_q;
    logic [3:0]      blank_q;
    logic            seg_err_q;
    logic            stale_q;

    logic            in_one, same, capture, legal, is_blank, cap_ok, stale_hit;
    logic [3:0]      val;
    logic [1:0]      sel;

    function automatic logic one_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    // Dwell tracking compares the incoming sample against the registered one.
    always_comb begin
        in_one     = one_low(AN);
        same       = (AN == an_q) && (SEG == seg_q);
        dwell_next = dwell;
        if (!in_one)
            dwell_next = '0;
        else if (!same)
            dwell_next = 8'd1;
        else if (dwell < 8'(SETTLE))
            dwell_next = dwell + 8'd1;
        capture = in_one && same && (dwell == 8'(SETTLE - 1));
    end

    // At a capture edge the registered sample equals the incoming one.
    always_comb begin
        legal    = 1'b1;
        is_blank = 1'b0;
        val      = '0;
        case (seg_q)
            7'h40: val = 4'h0;
            7'h79: val = 4'h1;
            7'h24: val = 4'h2;
            7'h30: val = 4'h3;
            7'h19: val = 4'h4;
            7'h12: val = 4'h5;
            7'h02: val = 4'h6;
            7'h78: val = 4'h7;
            7'h00: val = 4'h8;
            7'h10: val = 4'h9;
            7'h08: val = 4'hA;
            7'h03: val = 4'hB;
            7'h46: val = 4'hC;
            7'h21: val = 4'hD;
            7'h06: val = 4'hE;
            7'h0E: val = 4'hF;
            7'h7F: is_blank = 1'b1;
            default: legal = 1'b0;
        endcase
        case (an_q)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            default: sel = 2'd3;
        endcase
        cap_ok    = capture && legal;
        stale_hit = !cap_ok && (idle == IW'(TIMEOUT - 1));
    end

    always_comb begin
        mask_next = mask;
        if (state == COMMIT || stale_hit || (capture && !legal))
            mask_next = '0;
        if (cap_ok)
            mask_next = mask_next | (4'b0001 << sel);

        state_next = state;
        case (state)
            COLLECT: if (mask_next == 4'b1111) state_next = COMMIT;
            COMMIT:  state_next = COLLECT;
            default: state_next = COLLECT;
        endcase

        // The commit cycle already presents the shadow; registers catch up on exit.
        FRAME_VALID = (state == COMMIT);
        DIG0  = FRAME_VALID ? sh_val[0] : dig_q[0];
        DIG1  = FRAME_VALID ? sh_val[1] : dig_q[1];
        DIG2  = FRAME_VALID ? sh_val[2] : dig_q[2];
        DIG3  = FRAME_VALID ? sh_val[3] : dig_q[3];
        BLANK = FRAME_VALID ? sh_blank : blank_q;
        SEG_ERR = seg_err_q;
        STALE   = stale_q;
        AN_ERR  = (an_q != 4'b1111) && !one_low(an_q);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= COLLECT;
            an_q      <= '1;
            seg_q     <= '0;
            dwell     <= '0;
            idle      <= '0;
            mask      <= '0;
            sh_val    <= '0;
            sh_blank  <= '0;
            dig_q     <= '0;
            blank_q   <= '1;
            seg_err_q <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state     <= state_next;
            an_q      <= AN;
            seg_q     <= SEG;
            dwell     <= dwell_next;
            mask      <= mask_next;
            seg_err_q <= capture && !legal;
            if (cap_ok) begin
                sh_val[sel]   <= val;
                sh_blank[sel] <= is_blank;
                idle          <= '0;
                stale_q       <= 1'b0;
            end else begin
                if (idle != IW'(TIMEOUT))
                    idle <= idle + 1'b1;
                if (stale_hit)
                    stale_q <= 1'b1;
            end
            if (state == COMMIT) begin
                dig_q   <= sh_val;
                blank_q <= sh_blank;
            end
        end
    end

endmodule
